// File: rtl/acc_core_param_if.sv
// Instruction handshake, status and debug-read bundle between the feed logic and acc_core_param.
interface acc_core_param_if #(
  parameter int DATA_W = 8,
  parameter int NREGS  = 8,
  parameter int PC_W   = 9
) ();
  localparam int RA      = $clog2(NREGS);
  localparam int INSTR_W = 4 + 2 * RA + DATA_W;

  logic [INSTR_W-1:0] INSTRUCTION;
  logic               write_en;
  logic               ready;
  logic [PC_W-1:0]    PC;
  logic [DATA_W-1:0]  result;
  logic               result_valid;
  logic               zero;
  logic               carry;
  logic               halted;
  logic [RA-1:0]      dbg_addr;
  logic [DATA_W-1:0]  dbg_data;

  // Instruction feeder / debug reader side
  modport master (
    output INSTRUCTION, write_en, dbg_addr,
    input  ready, PC, result, result_valid, zero, carry, halted, dbg_data
  );

  // Core side
  modport slave (
    input  INSTRUCTION, write_en, dbg_addr,
    output ready, PC, result, result_valid, zero, carry, halted, dbg_data
  );
endinterface

// File: rtl/acc_core_param.sv
// Parametrised accumulator-style CPU core: register file, ALU, PC and a
// two-cycle accept/execute FSM with a terminal HALT state.
module acc_core_param #(
  parameter int DATA_W  = 8,
  parameter int NREGS   = 8,
  parameter int PC_W    = 9,
  parameter int PC_STEP = 4
) (
  input logic              CLK,
  input logic              RESET,
  acc_core_param_if.slave  bus
);
  localparam int RA      = $clog2(NREGS);
  localparam int SW      = $clog2(DATA_W);
  localparam int INSTR_W = 4 + 2 * RA + DATA_W;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_EXEC = 2'd1;
  localparam logic [1:0] S_HALT = 2'd2;

  localparam logic [3:0] OP_LOADI = 4'd0;
  localparam logic [3:0] OP_MOV   = 4'd1;
  localparam logic [3:0] OP_ADD   = 4'd2;
  localparam logic [3:0] OP_SUB   = 4'd3;
  localparam logic [3:0] OP_AND   = 4'd4;
  localparam logic [3:0] OP_OR    = 4'd5;
  localparam logic [3:0] OP_SRL   = 4'd6;
  localparam logic [3:0] OP_ADDI  = 4'd7;
  localparam logic [3:0] OP_HALT  = 4'd8;

  localparam logic [DATA_W:0] ONE_X   = 1;
  localparam logic [PC_W-1:0] PC_INCR = PC_W'(PC_STEP);

  logic [1:0]         state;
  logic [PC_W-1:0]    pc;
  logic [DATA_W-1:0]  result_q;
  logic               result_vld;
  logic               zero_q;
  logic               carry_q;
  logic [DATA_W-1:0]  regs [NREGS];

  logic [INSTR_W-1:0] instr_p0;
  logic [3:0]         op_p0;
  logic [RA-1:0]      rd_p0;
  logic [RA-1:0]      rs1_p0;
  logic [RA-1:0]      rs2_p0;
  logic [DATA_W-1:0]  opnd_p0;

  logic [DATA_W-1:0]  op_a;
  logic [DATA_W-1:0]  op_b;
  logic [DATA_W:0]    ext_c;
  logic               wr_en_c;
  logic [DATA_W-1:0]  wr_val_c;
  logic               c_upd_c;
  logic               c_val_c;
  logic               halt_c;
  logic               accept;

  // Only an idle core takes an instruction; write_en in any other state is dropped.
  assign accept = (state == S_IDLE) && bus.write_en;

  assign op_p0   = instr_p0[INSTR_W-1 -: 4];
  assign rd_p0   = instr_p0[INSTR_W-5 -: RA];
  assign rs1_p0  = instr_p0[DATA_W+RA-1 -: RA];
  assign opnd_p0 = instr_p0[DATA_W-1:0];
  assign rs2_p0  = opnd_p0[RA-1:0];

  // ---- stage p0: instruction latch (data only, no reset needed) ----
  // Capture the accepted instruction for the following EXEC cycle.
  always_ff @(posedge CLK) begin
    if (accept) begin
      instr_p0 <= bus.INSTRUCTION;
    end
  end

  // ---- stage p1: execute, operands read from the current register contents ----
  // Decode the latched instruction into a write value, flag updates and halt request.
  always_comb begin
    op_a     = regs[rs1_p0];
    op_b     = regs[rs2_p0];
    ext_c    = '0;
    wr_en_c  = 1'b0;
    wr_val_c = '0;
    c_upd_c  = 1'b0;
    c_val_c  = 1'b0;
    halt_c   = 1'b0;
    case (op_p0)
      OP_LOADI: begin
        wr_en_c  = 1'b1;
        wr_val_c = opnd_p0;
      end
      OP_MOV: begin
        wr_en_c  = 1'b1;
        wr_val_c = op_b;
      end
      OP_ADD: begin
        ext_c    = {1'b0, op_a} + {1'b0, op_b};
        wr_en_c  = 1'b1;
        wr_val_c = ext_c[DATA_W-1:0];
        c_upd_c  = 1'b1;
        c_val_c  = ext_c[DATA_W];
      end
      OP_SUB: begin
        // Carry out of a + ~b + 1 is the "no borrow" bit, i.e. a >= b unsigned.
        ext_c    = {1'b0, op_a} + {1'b0, ~op_b} + ONE_X;
        wr_en_c  = 1'b1;
        wr_val_c = ext_c[DATA_W-1:0];
        c_upd_c  = 1'b1;
        c_val_c  = ext_c[DATA_W];
      end
      OP_AND: begin
        wr_en_c  = 1'b1;
        wr_val_c = op_a & op_b;
      end
      OP_OR: begin
        wr_en_c  = 1'b1;
        wr_val_c = op_a | op_b;
      end
      OP_SRL: begin
        wr_en_c  = 1'b1;
        wr_val_c = op_a >> opnd_p0[SW-1:0];
      end
      OP_ADDI: begin
        ext_c    = {1'b0, op_a} + {1'b0, opnd_p0};
        wr_en_c  = 1'b1;
        wr_val_c = ext_c[DATA_W-1:0];
        c_upd_c  = 1'b1;
        c_val_c  = ext_c[DATA_W];
      end
      OP_HALT: begin
        halt_c = 1'b1;
      end
      default: begin
      end
    endcase
  end

  // ---- stage p1 -> architectural state: FSM, PC, register file, flags, result ----
  // Sequence IDLE -> EXEC -> IDLE/HALT and retire the executed instruction.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state      <= S_IDLE;
      pc         <= '0;
      result_q   <= '0;
      result_vld <= 1'b0;
      zero_q     <= 1'b0;
      carry_q    <= 1'b0;
      for (int i = 0; i < NREGS; i++) begin
        regs[i] <= '0;
      end
    end else begin
      result_vld <= 1'b0;
      case (state)
        S_IDLE: begin
          if (accept) begin
            state <= S_EXEC;
          end
        end
        S_EXEC: begin
          if (halt_c) begin
            state <= S_HALT;
          end else begin
            state <= S_IDLE;
            pc    <= pc + PC_INCR;
            if (wr_en_c) begin
              regs[rd_p0] <= wr_val_c;
              result_q    <= wr_val_c;
              result_vld  <= 1'b1;
              zero_q      <= (wr_val_c == '0);
            end
            if (c_upd_c) begin
              carry_q <= c_val_c;
            end
          end
        end
        S_HALT: begin
          state <= S_HALT;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.ready        = (state == S_IDLE);
  assign bus.halted       = (state == S_HALT);
  assign bus.PC           = pc;
  assign bus.result       = result_q;
  assign bus.result_valid = result_vld;
  assign bus.zero         = zero_q;
  assign bus.carry        = carry_q;
  assign bus.dbg_data     = regs[bus.dbg_addr];

endmodule

// File: tb/tb_acc_core_param.sv
// Bench for acc_core_param: directed instruction sequences, an instruction-level
// reference model checked every cycle, and literal spot checks of key results.
module tb_acc_core_param;
  localparam int DATA_W  = 8;
  localparam int NREGS   = 8;
  localparam int PC_W    = 9;
  localparam int PC_STEP = 4;

  logic CLK   = 1'b0;
  logic RESET = 1'b1;

  acc_core_param_if #(.DATA_W(DATA_W), .NREGS(NREGS), .PC_W(PC_W)) bus ();

  acc_core_param #(
    .DATA_W(DATA_W), .NREGS(NREGS), .PC_W(PC_W), .PC_STEP(PC_STEP)
  ) dut (
    .CLK  (CLK),
    .RESET(RESET),
    .bus  (bus)
  );

  always #5 CLK = ~CLK;

  int n_cmp  = 0;
  int n_err  = 0;
  int rv_cnt = 0;
  bit chk_en = 1'b0;

  // Reference model state: instruction-level semantics with plain integers.
  int          m_regs [NREGS];
  int          m_pc     = 0;
  int          m_result = 0;
  bit          m_rv     = 1'b0;
  bit          m_zero   = 1'b0;
  bit          m_carry  = 1'b0;
  bit          m_halt   = 1'b0;
  bit          m_pend   = 1'b0;
  logic [17:0] m_instr  = '0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [17:0] mk(input int op, input int rd, input int rs1, input int opnd);
    return {4'(op), 3'(rd), 3'(rs1), 8'(opnd)};
  endfunction

  task automatic model_exec(input logic [17:0] ins);
    int op, rd, a, b, imm, v;
    bit wr;
    op  = int'(ins[17:14]);
    rd  = int'(ins[13:11]);
    a   = m_regs[int'(ins[10:8])];
    imm = int'(ins[7:0]);
    b   = m_regs[imm % NREGS];
    wr  = 1'b1;
    v   = 0;
    case (op)
      0: v = imm;
      1: v = b;
      2: begin v = a + b;   m_carry = (v > 255); end
      3: begin v = a - b;   m_carry = (a >= b);  end
      4: v = a & b;
      5: v = a | b;
      6: v = a >> (imm % 8);
      7: begin v = a + imm; m_carry = (v > 255); end
      8: begin m_halt = 1'b1; wr = 1'b0; end
      default: wr = 1'b0;
    endcase
    v = v & 255;
    if (op != 8) m_pc = (m_pc + PC_STEP) % 512;
    if (wr) begin
      m_regs[rd] = v;
      m_result   = v;
      m_rv       = 1'b1;
      m_zero     = (v == 0);
    end
  endtask

  // Model advances on each rising edge using the inputs that are stable there.
  always @(posedge CLK) begin
    if (RESET) begin
      for (int i = 0; i < NREGS; i++) m_regs[i] = 0;
      m_pc = 0; m_result = 0; m_rv = 0; m_zero = 0; m_carry = 0; m_halt = 0; m_pend = 0;
    end else begin
      m_rv = 1'b0;
      if (m_pend) begin
        m_pend = 1'b0;
        model_exec(m_instr);
      end else if (!m_halt && bus.write_en) begin
        m_pend  = 1'b1;
        m_instr = bus.INSTRUCTION;
      end
    end
  end

  // Per-cycle comparison of every output against the model, just after the edge.
  always @(posedge CLK) begin
    #1;
    if (chk_en) begin
      chk("ready",        32'(bus.ready),        32'(!m_pend && !m_halt));
      chk("halted",       32'(bus.halted),       32'(m_halt));
      chk("pc",           32'(bus.PC),           32'(m_pc));
      chk("result_valid", 32'(bus.result_valid), 32'(m_rv));
      chk("result",       32'(bus.result),       32'(m_result));
      chk("zero",         32'(bus.zero),         32'(m_zero));
      chk("carry",        32'(bus.carry),        32'(m_carry));
      chk("dbg_data",     32'(bus.dbg_data),     32'(m_regs[int'(bus.dbg_addr)]));
      if (bus.result_valid === 1'b1) rv_cnt++;
    end
  end

  task automatic issue(input logic [17:0] ins);
    bus.dbg_addr    = bus.dbg_addr + 3'd1;
    bus.INSTRUCTION = ins;
    bus.write_en    = 1'b1;
    @(negedge CLK);
    bus.write_en = 1'b0;
    @(negedge CLK);
  endtask

  task automatic lit(input string nm, input int addr, input int exp);
    bus.dbg_addr = 3'(addr);
    #1;
    chk(nm, 32'(bus.dbg_data), 32'(exp));
    chk({nm, "_model"}, 32'(m_regs[addr]), 32'(exp));
    @(negedge CLK);
  endtask

  initial begin
    bus.INSTRUCTION = '0;
    bus.write_en    = 1'b0;
    bus.dbg_addr    = '0;

    // Reset for two cycles, then idle while sweeping the debug port.
    @(negedge CLK);
    chk_en = 1'b1;
    @(negedge CLK);
    RESET = 1'b0;
    chk("rst_ready",  32'(bus.ready),  32'd1);
    chk("rst_pc",     32'(bus.PC),     32'd0);
    chk("rst_halted", 32'(bus.halted), 32'd0);
    for (int i = 0; i < NREGS; i++) lit("rst_reg", i, 0);
    chk("rst_no_rv",  32'(rv_cnt), 32'd0);

    // LOADI / LOADI / ADD with carry out.
    rv_cnt = 0;
    issue(mk(0, 1, 0, 8'hF0));
    issue(mk(0, 2, 0, 8'h20));
    issue(mk(2, 3, 1, 2));
    lit("add_r3", 3, 8'h10);
    chk("add_carry", 32'(bus.carry), 32'd1);
    chk("add_zero",  32'(bus.zero),  32'd0);
    chk("add_pc",    32'(bus.PC),    32'd12);
    chk("add_rv_cnt", 32'(rv_cnt),   32'd3);

    // SUB with borrow, SUB to zero, AND / OR.
    issue(mk(3, 4, 2, 1));
    lit("sub_r4", 4, 8'h30);
    chk("sub_carry0", 32'(bus.carry), 32'd0);
    issue(mk(3, 5, 1, 1));
    lit("sub_r5", 5, 0);
    chk("sub_zero1",  32'(bus.zero),  32'd1);
    chk("sub_carry1", 32'(bus.carry), 32'd1);
    issue(mk(0, 6, 0, 8'h3C));
    issue(mk(4, 7, 1, 6));
    lit("and_r7", 7, 8'h30);
    issue(mk(5, 7, 1, 6));
    lit("or_r7", 7, 8'hFC);
    chk("or_carry_held", 32'(bus.carry), 32'd1);

    // Logical right shifts, then a NOP that must leave the flags alone.
    issue(mk(6, 1, 1, 3));
    lit("srl3_r1", 1, 8'h1E);
    issue(mk(0, 2, 0, 8'h80));
    issue(mk(6, 2, 2, 7));
    lit("srl7_r2", 2, 8'h01);
    issue(mk(9, 0, 0, 0));
    chk("nop_pc", 32'(bus.PC), 32'd48);

    // A second instruction offered only during EXEC must be dropped.
    bus.INSTRUCTION = mk(0, 0, 0, 8'h11);
    bus.write_en    = 1'b1;
    @(negedge CLK);
    bus.INSTRUCTION = mk(0, 0, 0, 8'h22);
    @(negedge CLK);
    bus.write_en = 1'b0;
    @(negedge CLK);
    lit("busy_drop_r0", 0, 8'h11);
    chk("busy_drop_pc", 32'(bus.PC), 32'd52);

    // HALT freezes the core until reset.
    issue(mk(8, 0, 0, 0));
    bus.INSTRUCTION = mk(0, 3, 0, 8'h99);
    bus.write_en    = 1'b1;
    repeat (4) @(negedge CLK);
    bus.write_en = 1'b0;
    chk("halt_halted", 32'(bus.halted), 32'd1);
    chk("halt_ready",  32'(bus.ready),  32'd0);
    chk("halt_pc",     32'(bus.PC),     32'd52);
    lit("halt_r3", 3, 8'h10);
    RESET = 1'b1;
    @(negedge CLK);
    RESET = 1'b0;
    chk("rec_ready",  32'(bus.ready),  32'd1);
    chk("rec_halted", 32'(bus.halted), 32'd0);
    chk("rec_pc",     32'(bus.PC),     32'd0);
    lit("rec_r3", 3, 0);

    // Reset landing on the EXEC cycle aborts the write.
    rv_cnt = 0;
    bus.INSTRUCTION = mk(0, 6, 0, 8'h55);
    bus.write_en    = 1'b1;
    @(negedge CLK);
    bus.write_en = 1'b0;
    RESET = 1'b1;
    @(negedge CLK);
    RESET = 1'b0;
    @(negedge CLK);
    lit("abort_r6", 6, 0);
    chk("abort_rv_cnt", 32'(rv_cnt), 32'd0);

    // write_en together with reset is not accepted.
    RESET = 1'b1;
    bus.write_en = 1'b1;
    @(negedge CLK);
    RESET = 1'b0;
    bus.write_en = 1'b0;
    chk("rst_we_ready", 32'(bus.ready), 32'd1);
    @(negedge CLK);
    issue(mk(0, 6, 0, 8'h55));
    lit("post_r6", 6, 8'h55);
    chk("post_pc", 32'(bus.PC), 32'd4);

    // PC wrap after 128 retired NOPs from PC 0.
    RESET = 1'b1;
    @(negedge CLK);
    RESET = 1'b0;
    rv_cnt = 0;
    for (int i = 1; i <= 128; i++) begin
      issue(mk(9, 0, 0, 0));
      if (i == 127) chk("wrap_pc127", 32'(bus.PC), 32'd508);
      if (i == 128) chk("wrap_pc128", 32'(bus.PC), 32'd0);
    end
    chk("nop_rv_cnt", 32'(rv_cnt), 32'd0);

    repeat (2) @(negedge CLK);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
